// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: owns the PC, drives the instruction ROM and fills the IF/ID register.
// Optional build macro BRANCH_DELAY_SLOT_EN keeps the fall-through word on a taken branch (delay slot).
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        rom_chip_enable,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid
);

    logic [31:0] pc;
    logic        fetch_en;
    logic [31:0] id_pc_r;
    logic [31:0] id_instr_r;
    logic        id_valid_r;

    logic [31:0] pc_next;
    logic        fetch_en_next;
    logic [31:0] id_pc_next;
    logic [31:0] id_instr_next;
    logic        id_valid_next;

    // Redirect addresses are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    always_comb begin
        pc_next       = pc;
        fetch_en_next = 1'b1;
        id_pc_next    = id_pc_r;
        id_instr_next = id_instr_r;
        id_valid_next = id_valid_r;

        if (!fetch_en) begin
            pc_next       = RESET_PC;
            id_pc_next    = 32'h0;
            id_instr_next = 32'h0;
            id_valid_next = 1'b0;
        end else if (flush) begin
            pc_next       = word_align(flush_pc);
            id_pc_next    = 32'h0;
            id_instr_next = 32'h0;
            id_valid_next = 1'b0;
        end else if (stall) begin
            // ID keeps presenting any pending branch, so it is safe to ignore it here.
            pc_next = pc;
        end else if (branch_taken) begin
            pc_next = word_align(branch_target);
`ifdef BRANCH_DELAY_SLOT_EN
            id_pc_next    = pc;
            id_instr_next = rom_instruction;
            id_valid_next = 1'b1;
`else
            id_pc_next    = 32'h0;
            id_instr_next = 32'h0;
            id_valid_next = 1'b0;
`endif
        end else begin
            pc_next       = pc + 32'd4;
            id_pc_next    = pc;
            id_instr_next = rom_instruction;
            id_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            fetch_en   <= 1'b0;
            id_pc_r    <= 32'h0;
            id_instr_r <= 32'h0;
            id_valid_r <= 1'b0;
        end else begin
            pc         <= pc_next;
            fetch_en   <= fetch_en_next;
            id_pc_r    <= id_pc_next;
            id_instr_r <= id_instr_next;
            id_valid_r <= id_valid_next;
        end
    end

    assign rom_addr        = pc;
    assign rom_chip_enable = fetch_en;
    assign id_pc           = id_pc_r;
    assign id_instruction  = id_instr_r;
    assign id_valid        = id_valid_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset/startup, stall, branch, flush priority, wrap and async reset.
// The ROM is modelled as word(addr) = addr ^ 32'hC0DE_0000.
module tb_inst_fetch;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        rom_chip_enable;
    logic [31:0] rom_addr;
    logic [31:0] rom_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;

    int vectors = 0;
    int miscompares = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .rom_chip_enable (rom_chip_enable),
        .rom_addr        (rom_addr),
        .rom_instruction (rom_instruction),
        .id_pc           (id_pc),
        .id_instruction  (id_instruction),
        .id_valid        (id_valid)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign rom_instruction = word(rom_addr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_id(input string tag, input logic v, input logic [31:0] p, input logic [31:0] ins);
        check({tag, "_valid"}, {31'h0, id_valid}, {31'h0, v});
        check({tag, "_pc"}, id_pc, p);
        check({tag, "_instr"}, id_instruction, ins);
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        branch_taken = 1'b0; branch_target = 32'h0;

        // Reset held for three cycles
        repeat (3) tick();
        check("rst_ce", {31'h0, rom_chip_enable}, 32'h0);
        check("rst_addr", rom_addr, 32'h0);
        check_id("rst", 1'b0, 32'h0, 32'h0);

        reset_n = 1'b1;
        tick();
        check("start_ce", {31'h0, rom_chip_enable}, 32'h1);
        check("start_addr", rom_addr, 32'h0);
        check_id("start", 1'b0, 32'h0, 32'h0);

        tick();
        check("seq0_addr", rom_addr, 32'h4);
        check_id("seq0", 1'b1, 32'h0, 32'hC0DE_0000);
        tick();
        check("seq1_addr", rom_addr, 32'h8);
        check_id("seq1", 1'b1, 32'h4, 32'hC0DE_0004);

        // Stall for three cycles at rom_addr 8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr", rom_addr, 32'h8);
            check_id("stall", 1'b1, 32'h4, 32'hC0DE_0004);
        end
        stall = 1'b0;
        tick();
        check("unstall_addr", rom_addr, 32'hC);
        check_id("unstall", 1'b1, 32'h8, 32'hC0DE_0008);

        // Taken branch from C to 40
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        check("br_addr", rom_addr, 32'h40);
`ifdef BRANCH_DELAY_SLOT_EN
        check_id("br_slot", 1'b1, 32'hC, 32'hC0DE_000C);
`else
        check_id("br_bubble", 1'b0, 32'h0, 32'h0);
`endif
        tick();
        check("br_next_addr", rom_addr, 32'h44);
        check_id("br_tgt", 1'b1, 32'h40, 32'hC0DE_0040);

        // Flush together with stall and branch: flush wins
        flush = 1'b1; flush_pc = 32'h180; stall = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        flush = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        check("fl_addr", rom_addr, 32'h180);
        check_id("fl_bubble", 1'b0, 32'h0, 32'h0);
        tick();
        check("fl_next_addr", rom_addr, 32'h184);
        check_id("fl_tgt", 1'b1, 32'h180, 32'hC0DE_0180);

        // Misaligned branch near the top of the address space, then wrap
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        tick();
        branch_taken = 1'b0;
        check("wrap_addr", rom_addr, 32'hFFFF_FFFC);
`ifdef BRANCH_DELAY_SLOT_EN
        check_id("wrap_slot", 1'b1, 32'h184, 32'hC0DE_0184);
`else
        check_id("wrap_bubble", 1'b0, 32'h0, 32'h0);
`endif
        tick();
        check("wrap0_addr", rom_addr, 32'h0);
        check_id("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'h3F21_FFFC);
        tick();
        check("wrap4_addr", rom_addr, 32'h4);
        check_id("wrap_zero", 1'b1, 32'h0, 32'hC0DE_0000);

        // Reach rom_addr 20, then drop reset between edges
        branch_taken = 1'b1; branch_target = 32'h20;
        tick();
        branch_taken = 1'b0;
        check("pre_rst_addr", rom_addr, 32'h20);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ce", {31'h0, rom_chip_enable}, 32'h0);
        check("arst_addr", rom_addr, 32'h0);
        check_id("arst", 1'b0, 32'h0, 32'h0);

        tick();
        reset_n = 1'b1;
        tick();
        check("restart_ce", {31'h0, rom_chip_enable}, 32'h1);
        tick();
        check("restart_addr", rom_addr, 32'h4);
        check_id("restart", 1'b1, 32'h0, 32'hC0DE_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter and drives the combinational instruction ROM's `chip_enable`/`addr` pair. It latches the returned word into the IF/ID pipeline register. It applies stall, flush and branch redirects from downstream control, handling the branch delay slot per build configuration.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset; bits [1:0] must be 0.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `stall`  in  1  hazard-unit stall; hold PC and IF/ID.
- `flush`  in  1  exception/pipeline flush request.
- `flush_pc`  in  32  redirect address accompanying `flush`.
- `branch_taken`  in  1  ID-stage resolved taken branch/jump.
- `branch_target`  in  32  target address accompanying `branch_taken`.
- `rom_chip_enable`  out  1  fetch enable to instruction ROM.
- `rom_addr`  out  32  fetch byte address (current PC).
- `rom_instruction`  in  32  ROM read data, valid combinationally in the same cycle.
- `id_pc`  out  32  PC of instruction held in IF/ID.
- `id_instruction`  out  32  instruction held in IF/ID.
- `id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- State: `pc` (32-bit), `fetch_en` (1-bit), IF/ID register (`id_pc`, `id_instruction`, `id_valid`).
- `rom_addr` = `pc`. `rom_chip_enable` = `fetch_en`. Both are register outputs with no combinational path from inputs.
- `fetch_en` resets to 0 and becomes 1 on the first edge after reset release. It stays 1 until the next reset. While `fetch_en` = 0, `pc` holds `RESET_PC` and IF/ID loads a bubble.
- A bubble means `id_valid`=0, `id_instruction`=32'h0 (MIPS nop), `id_pc`=32'h0.
- Per-edge priority when `fetch_en`=1:
  1. `flush`: `pc` ← {`flush_pc`[31:2], 2'b00}; IF/ID ← bubble. `stall` and `branch_taken` are ignored.
  2. `stall`: `pc` and IF/ID hold. `branch_taken` is ignored; ID re-presents it after the stall.
  3. `branch_taken`: `pc` ← {`branch_target`[31:2], 2'b00}. IF/ID handling depends on the Configuration section.
  4. Otherwise: `pc` ← `pc` + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0). IF/ID ← {`pc`, `rom_instruction`, 1}.
- Address bits [1:0] of `flush_pc` and `branch_target` are discarded. `pc`[1:0] is always 00.

## Timing
- Reset values: `pc`=`RESET_PC`, `rom_addr`=`RESET_PC`, `rom_chip_enable`=0, `id_pc`=0, `id_instruction`=0, `id_valid`=0.
- Reset assertion mid-operation clears all state immediately, without waiting for a clock edge.
- Fetch latency: a word addressed in cycle N appears on `id_instruction` after edge N+1.
- Redirect latency:
  - `branch_taken` or `flush` sampled at edge E puts the target on `rom_addr` after E.
  - The target instruction reaches ID after E+1.
- Steady state: one instruction per cycle.
- Stall holds for an arbitrary number of cycles. Release resumes with the held PC, so nothing is dropped or duplicated.
- `flush` and `stall` together: flush wins.
- `flush` and `branch_taken` together: flush wins and `branch_target` is discarded.

## Configuration
- Macro `BRANCH_DELAY_SLOT_EN` (defined in `utility/utility.v` or on the command line).
- Defined, MIPS delay-slot semantics:
  - On a taken branch, IF/ID ← {`pc`, `rom_instruction`, 1}. The instruction after the branch still executes.
  - Redirect costs 0 bubbles.
- Undefined, no delay slot:
  - On a taken branch, IF/ID ← bubble. The fall-through instruction is squashed.
  - Redirect costs 1 bubble.
- The macro affects only priority case 3.

## Test plan
- **Reset and startup**, `RESET_PC`=0:
  - Hold `reset_n`=0 for 3 cycles, then release → `rom_chip_enable`=0 and `id_valid`=0 during reset.
  - First edge after release → `rom_chip_enable`=1, `rom_addr`=0.
  - Subsequent `id_pc` sequence is 0, 4, 8 with matching ROM words.
- **Stall**:
  - Assert `stall` for 3 cycles while `rom_addr`=8 → `rom_addr` stays 8; `id_pc`/`id_instruction` hold 4 and its word.
  - On release → `id_pc`=8 next, with no gap or duplicate.
- **Branch**:
  - Assert `branch_taken` with `branch_target`=32'h40 while `rom_addr`=32'hC → next `rom_addr`=32'h40.
  - With `BRANCH_DELAY_SLOT_EN`, `id_pc` goes C then 40.
  - Without it, `id_valid`=0 for one cycle, then `id_pc`=40.
- **Flush priority**:
  - Assert `flush` (`flush_pc`=32'h180), `stall` and `branch_taken` (target 32'h40) in the same cycle → `rom_addr`=32'h180.
  - `id_valid`=0 for one cycle, then `id_pc`=32'h180.
- **Wrap and alignment**:
  - Branch to 32'hFFFF_FFFE → `rom_addr`=32'hFFFF_FFFC, then next cycle 0.
- **Asynchronous reset mid-stream**:
  - Drop `reset_n` between edges while `rom_addr`=32'h20 → outputs go to reset values before the next edge.
